mix_cols_engine: RTL and testbench
==================================

Name: mix_cols_engine

Overview:
Multi-cycle AES MixColumns / InvMixColumns engine for a full 128-bit state. It sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round datapath. It processes COLS_PER_CYCLE columns per clock and selects encrypt or decrypt matrix per transaction. Valid/ready handshakes on input and output let it trade area for throughput without changing the surrounding round controller.

Parameters:
COLS_PER_CYCLE, 1, number of columns transformed per clock; legal values 1, 2, 4; other values are an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  in_state/in_mode/in_bypass are valid
in_ready  output  1  engine can accept a transaction this cycle
in_state  input  128  state; column c = bits[127-32c -: 32]; row 0 byte is the column MSB
in_mode  input  1  0 = MixColumns (02 03 01 01), 1 = InvMixColumns (0E 0B 0D 09)
in_bypass  input  1  1 = pass state unchanged (final round); latency unchanged
out_valid  output  1  out_state holds a completed result
out_ready  input  1  consumer accepts out_state
out_state  output  128  transformed state, same packing as in_state
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM to IDLE, out_valid=0, busy=0, in_ready=1 on the following cycle, out_state=0, column counter=0. A transaction in flight is discarded; no output is produced for it.
- Accept: in_valid & in_ready at edge T → latch in_state, in_mode, in_bypass; FSM to RUN; counter=0. Mode and bypass are fixed for the whole transaction.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. Accept → RUN.
  - RUN: in_ready=0. Each cycle, transform columns counter..counter+COLS_PER_CYCLE-1 in place; counter += COLS_PER_CYCLE. Last group → DONE.
  - DONE: out_valid=1, out_state stable. out_ready=1 → result consumed.
- Latency: N = 4/COLS_PER_CYCLE. Accept at edge T; out_valid=1 in the cycle after edge T+N (COLS_PER_CYCLE=4 gives 1 cycle, 1 gives 4 cycles).
- Back-to-back: in DONE, in_ready = out_ready. A simultaneous consume and accept goes straight to RUN with no IDLE bubble. Consume without accept → IDLE.
- Backpressure: out_ready=0 in DONE holds out_valid and out_state indefinitely; in_ready stays 0.
- in_valid=0 or in_ready=0: inputs ignored. No output is produced without an accepted input.
- Column transform, per column bytes (a0..a3), row 0 = MSB:
  - mode 0: b_r = 02·a_r ^ 03·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - mode 1: b_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3).
  - Multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1 (0x11B), built from xtime chains, not LUTs.
- Bypass: columns are written back unchanged; cycle timing is identical to a real transform.
- The state register is a single 128-bit register updated in place and drives out_state directly, so out_state is registered.

Decomposition:
- aes_pkg: xtime function, gf_mul function for constants 02/03/09/0B/0D/0E, MODE_ENC=0 / MODE_DEC=1 constants, FSM state enum {IDLE, RUN, DONE}.
- Sub-module mix_col_unit: combinational, 32-bit column in, mode in, 32-bit column out. Instantiated COLS_PER_CYCLE times, with a mux selecting the column group by counter.

Test Plan:
- FIPS-197 column, mode 0, COLS_PER_CYCLE=1: column db135345 replicated in all 4 columns → every column 8e4da1bc; out_valid rises 4 cycles after accept.
- Mixed columns, mode 0: f20a225c_01010101_c6c6c6c6_d4d4d4d5 → 9fdc589d_01010101_c6c6c6c6_d5d5d7d6.
- Inverse, mode 1: 8e4da1bc_4d7ebdf8_9fdc589d_01010101 → db135345_2d26314c_f20a225c_01010101. Round-trip any random state through mode 0 then mode 1 → original.
- Bypass=1, mode 0, state 00112233_44556677_8899aabb_ccddeeff → identical output at the same latency; repeat with COLS_PER_CYCLE=4 → out_valid 1 cycle after accept.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles → out_state stable and in_ready=0. Then assert out_ready with in_valid=1 → new transaction accepted in the same cycle and result returned N cycles later.
- Reset mid-RUN: drive rst_n=0 at counter=2 → next cycle out_valid=0, busy=0, in_ready=1. No stale output appears afterward.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: GF(2^8) helpers, mode encoding, FSM states.
package aes_pkg;

    localparam logic MODE_ENC = 1'b0;   // MixColumns     (02 03 01 01)
    localparam logic MODE_DEC = 1'b1;   // InvMixColumns  (0E 0B 0D 09)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply built from an xtime chain; only the MixColumns
    // coefficients are supported, anything else yields zero.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            8'h01:   r = a;
            8'h02:   r = x2;
            8'h03:   r = x2 ^ a;
            8'h09:   r = x8 ^ a;
            8'h0b:   r = x8 ^ x2 ^ a;
            8'h0d:   r = x8 ^ x4 ^ a;
            8'h0e:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// Combinational single-column MixColumns / InvMixColumns transform.
// Row 0 byte is the column MSB.
module mix_col_unit
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_mode,
    output logic [31:0] o_col
);

    logic [7:0] w_a   [4];
    logic [7:0] w_enc [4];
    logic [7:0] w_dec [4];

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign w_a[r] = i_col[31-8*r -: 8];
    end

    // Each output row mixes the column bytes rotated so that row r leads.
    for (genvar r = 0; r < 4; r++) begin : g_mix
        assign w_enc[r] = gf_mul(w_a[r], 8'h02)       ^ gf_mul(w_a[(r+1)%4], 8'h03) ^
                          w_a[(r+2)%4]                ^ w_a[(r+3)%4];
        assign w_dec[r] = gf_mul(w_a[r], 8'h0e)       ^ gf_mul(w_a[(r+1)%4], 8'h0b) ^
                          gf_mul(w_a[(r+2)%4], 8'h0d) ^ gf_mul(w_a[(r+3)%4], 8'h09);
        assign o_col[31-8*r -: 8] = (i_mode == MODE_DEC) ? w_dec[r] : w_enc[r];
    end

endmodule

// File: rtl/mix_cols_engine.sv
// Multi-cycle AES (Inv)MixColumns engine over a 128-bit state.
// Transforms COLS_PER_CYCLE columns per clock in place inside one state
// register, with valid/ready handshakes on both sides.
module mix_cols_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_mode,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
        $error("mix_cols_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Column counter steps by the group width; with 4 columns per cycle the
    // step truncates to 0 and the single group is also the last one.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    fsm_state_t   r_fsm;
    logic [127:0] r_state;
    logic [1:0]   r_col_idx;
    logic         r_mode;
    logic         r_bypass;
    logic         r_out_valid;
    logic         r_busy;

    logic [31:0]  w_cols      [4];
    logic [31:0]  w_next_cols [4];
    logic [127:0] w_state_next;
    logic [1:0]   w_grp_idx   [COLS_PER_CYCLE];
    logic [31:0]  w_grp_in    [COLS_PER_CYCLE];
    logic [31:0]  w_grp_out   [COLS_PER_CYCLE];
    logic [31:0]  w_grp_new   [COLS_PER_CYCLE];
    logic         w_in_ready;
    logic         w_accept;
    logic         w_last;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_cols[c]                     = r_state[127-32*c -: 32];
        assign w_state_next[127-32*c -: 32]  = w_next_cols[c];
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_grp
        assign w_grp_idx[g] = r_col_idx + 2'(g);
        assign w_grp_in[g]  = w_cols[w_grp_idx[g]];

        mix_col_unit u_mix_col_unit (
            .i_col  (w_grp_in[g]),
            .i_mode (r_mode),
            .o_col  (w_grp_out[g])
        );

        assign w_grp_new[g] = r_bypass ? w_grp_in[g] : w_grp_out[g];
    end

    // Merge the freshly transformed column group into the current state.
    always_comb begin
        // NOTE: every always_comb output gets a full default before any
        // conditional/indexed write, otherwise unwritten bits infer latches.
        for (int c = 0; c < 4; c++) begin
            w_next_cols[c] = w_cols[c];
        end
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            w_next_cols[w_grp_idx[g]] = w_grp_new[g];
        end
    end

    // In DONE a new input may enter in the same cycle the result leaves.
    assign w_in_ready = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = (r_col_idx == LAST_COL);

    // Control FSM and in-place state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_fsm       <= IDLE;
            // NOTE: the state register is reset on purpose because it drives
            // out_state directly and must read as zero after reset.
            r_state     <= '0;
            r_col_idx   <= '0;
            r_mode      <= MODE_ENC;
            r_bypass    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_fsm       <= RUN;
            r_state     <= in_state;
            r_mode      <= in_mode;
            r_bypass    <= in_bypass;
            r_col_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_fsm)
                RUN: begin
                    r_state   <= w_state_next;
                    r_col_idx <= r_col_idx + COL_STEP;
                    if (w_last) begin
                        r_fsm       <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                IDLE: ;
                default: begin
                    r_fsm       <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mix_cols_engine.sv
// Self-checking bench for mix_cols_engine: one instance with 1 column per
// cycle and one with 4, a scoreboard queue per instance, and directed
// latency / backpressure / reset checks.
module tb_mix_cols_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_state;
    logic         in_mode;
    logic         in_bypass;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [127:0] out_state1;
    logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [127:0] out_state4;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_stray1 = 0;
    int           n_stray4 = 0;
    logic [127:0] q1 [$];
    logic [127:0] q4 [$];

    always #5 clk = ~clk;

    mix_cols_engine #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_state(in_state), .in_mode(in_mode), .in_bypass(in_bypass),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_state(out_state1), .busy(busy1)
    );

    mix_cols_engine #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_state(in_state), .in_mode(in_mode), .in_bypass(in_bypass),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_state(out_state4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] st, input logic md, input logic bp);
        logic [7:0]   k [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] res = st;
        if (md) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
        else    begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
        if (!bp) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = st[127-32*c-8*r -: 8];
                for (int r = 0; r < 4; r++) begin
                    b = 8'h00;
                    for (int j = 0; j < 4; j++) b ^= gmul(a[(r+j)%4], k[j]);
                    res[127-32*c-8*r -: 8] = b;
                end
            end
        end
        return res;
    endfunction

    // Scoreboard monitors: a handshake seen here completes at the next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
            if (q1.size() == 0) n_stray1++;
            else check("dut1_sb_data", out_state1, q1.pop_front());
        end
        if (rst_n === 1'b1 && out_valid4 === 1'b1 && out_ready4 === 1'b1) begin
            if (q4.size() == 0) n_stray4++;
            else check("dut4_sb_data", out_state4, q4.pop_front());
        end
    end

    // Drive one transaction to the selected instance; returns just after the accept edge.
    task automatic send(input bit sel, input logic [127:0] st, input logic md, input logic bp,
                        input bit push_exp);
        bit ok = 1'b0;
        in_state  = st;
        in_mode   = md;
        in_bypass = bp;
        if (sel) in_valid4 = 1'b1; else in_valid1 = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((sel ? in_ready4 : in_ready1) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_wait", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        if (push_exp) begin
            if (sel) q4.push_back(model_state(st, md, bp));
            else     q1.push_back(model_state(st, md, bp));
        end
    endtask

    // Count edges from accept until out_valid is seen; compare with the expected latency.
    task automatic wait_out(input bit sel, input int lat, input string tag);
        int k;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if ((sel ? out_valid4 : out_valid1) === 1'b1) break;
        end
        check(tag, 128'(k), 128'(lat));
    endtask

    localparam logic [127:0] FIPS_IN  = {4{32'hdb135345}};
    localparam logic [127:0] FIPS_OUT = {4{32'h8e4da1bc}};
    localparam logic [127:0] MIX_IN   = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] MIX_OUT  = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] INV_IN   = 128'h8e4da1bc_4d7ebdf8_9fdc589d_01010101;
    localparam logic [127:0] INV_OUT  = 128'hdb135345_2d26314c_f20a225c_01010101;
    localparam logic [127:0] BP_ST    = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        logic [127:0] rnd, tmp, exp_x, y;
        int           seen;

        rst_n = 1'b0; in_valid1 = 1'b0; in_valid4 = 1'b0;
        out_ready1 = 1'b1; out_ready4 = 1'b1;
        in_state = '0; in_mode = 1'b0; in_bypass = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_out_valid", 128'(out_valid1), 128'(0));
        check("rst_busy",      128'(busy1),      128'(0));
        check("rst_in_ready",  128'(in_ready1),  128'(1));
        check("rst_out_state", out_state1,       128'(0));
        check("rst_out_state4", out_state4,      128'(0));

        // Known-answer transforms on the 1-column instance.
        send(0, FIPS_IN, 1'b0, 1'b0, 1'b1);
        wait_out(0, 4, "fips_latency");
        check("fips_state", out_state1, FIPS_OUT);

        send(0, MIX_IN, 1'b0, 1'b0, 1'b1);
        wait_out(0, 4, "mixed_latency");
        check("mixed_state", out_state1, MIX_OUT);

        send(0, INV_IN, 1'b1, 1'b0, 1'b1);
        wait_out(0, 4, "inv_latency");
        check("inv_state", out_state1, INV_OUT);

        // Round trip: forward then inverse must restore the original.
        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(0, rnd, 1'b0, 1'b0, 1'b1);
            wait_out(0, 4, "rt_fwd_latency");
            tmp = out_state1;
            send(0, tmp, 1'b1, 1'b0, 1'b0);
            q1.push_back(rnd);
            wait_out(0, 4, "rt_inv_latency");
            check("roundtrip", out_state1, rnd);
        end

        send(0, BP_ST, 1'b0, 1'b1, 1'b1);
        wait_out(0, 4, "bypass_latency");
        check("bypass_state", out_state1, BP_ST);
        @(posedge clk);
        #1;

        // Backpressure: result must hold while out_ready is low.
        out_ready1 = 1'b0;
        rnd   = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_x = model_state(rnd, 1'b0, 1'b0);
        send(0, rnd, 1'b0, 1'b0, 1'b1);
        wait_out(0, 4, "bp_latency");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_state", out_state1,         exp_x);
            check("bp_out_valid",  128'(out_valid1),   128'(1));
            check("bp_in_ready",   128'(in_ready1),    128'(0));
        end

        // Consume and accept in the same cycle.
        y = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_state = y; in_mode = 1'b1; in_bypass = 1'b0;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready1), 128'(1));
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        q1.push_back(model_state(y, 1'b1, 1'b0));
        check("b2b_busy",      128'(busy1),      128'(1));
        check("b2b_out_valid", 128'(out_valid1), 128'(0));
        wait_out(0, 4, "b2b_latency");
        @(posedge clk);
        #1;

        // Reset while the column counter is at 2: the transaction is dropped.
        send(0, MIX_IN, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 128'(out_valid1), 128'(0));
        check("midrst_busy",      128'(busy1),      128'(0));
        check("midrst_in_ready",  128'(in_ready1),  128'(1));
        check("midrst_out_state", out_state1,       128'(0));
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid1 !== 1'b0) seen++;
        end
        check("midrst_no_stale", 128'(seen), 128'(0));

        // Four columns per cycle: single-cycle latency.
        send(1, BP_ST, 1'b0, 1'b1, 1'b1);
        wait_out(1, 1, "p4_bypass_latency");
        check("p4_bypass_state", out_state4, BP_ST);
        send(1, MIX_IN, 1'b0, 1'b0, 1'b1);
        wait_out(1, 1, "p4_mixed_latency");
        check("p4_mixed_state", out_state4, MIX_OUT);
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(1, rnd, 1'b1, 1'b0, 1'b1);
        wait_out(1, 1, "p4_inv_latency");

        repeat (3) @(posedge clk);
        #1;
        check("sb1_drained", 128'(q1.size()), 128'(0));
        check("sb4_drained", 128'(q4.size()), 128'(0));
        check("dut1_stray",  128'(n_stray1),  128'(0));
        check("dut4_stray",  128'(n_stray4),  128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
